ddr2_stream_write_master: RTL and testbench



---
 rtl/ddr2_stream_write_master.sv | 199 +++++++++++++++++++
 tb/tb_ddr2_stream_write_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_stream_write_master.sv
// Avalon-MM burst write master: buffers a 32-bit sample stream in a local FIFO and
// writes it toward the DDR2 bridge as 2-beat bursts with a 1-beat tail.
module ddr2_stream_write_master #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 28,
  parameter int LEN_W      = 20
) (
  input  logic              slave_clk,
  input  logic              slave_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] av_address,
  output logic [1:0]        av_burstcount,
  output logic [3:0]        av_byteenable,
  output logic              av_write,
  output logic              av_read,
  output logic [31:0]       av_writedata,
  input  logic              av_waitrequest
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_BEAT1, S_BEAT2, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  wr_remain_q;
  logic [LEN_W-1:0]  rx_remain_q, rx_remain_d;
  logic              busy_q, done_q;
  logic              av_write_q;
  logic [ADDR_W-1:0] av_address_q;
  logic [1:0]        av_burstcount_q;
  logic [3:0]        av_byteenable_q;
  logic [31:0]       av_writedata_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt_s;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_full_s, push_s, pop_s;
  logic [1:0]        arm_bc_s;

  assign fifo_full_s  = (count_q == CNT_W'(FIFO_DEPTH));
  assign snk_ready    = busy_q & ~fifo_full_s & (rx_remain_q != {LEN_W{1'b0}});
  assign push_s       = snk_valid & snk_ready;
  assign pop_s        = av_write_q & ~av_waitrequest;
  assign rd_ptr_nxt_s = rd_ptr_q + PTR_W'(1);

  assign busy          = busy_q;
  assign done          = done_q;
  assign av_write      = av_write_q;
  assign av_address    = av_address_q;
  assign av_burstcount = av_burstcount_q;
  assign av_byteenable = av_byteenable_q;
  assign av_writedata  = av_writedata_q;
  assign av_read       = 1'b0;

  // Next FIFO occupancy and receive budget
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (state_q == S_IDLE && start) begin
      rx_remain_d = length;
    end else if (push_s) begin
      rx_remain_d = rx_remain_q - LEN_W'(1);
    end else begin
      rx_remain_d = rx_remain_q;
    end
  end

  // Burst size chosen in ARM; a lone beat only ever closes out the transfer
  always_comb begin
    if (wr_remain_q >= LEN_W'(2) && count_q >= CNT_W'(2)) begin
      arm_bc_s = 2'd2;
    end else if (wr_remain_q == LEN_W'(1) && count_q >= CNT_W'(1)) begin
      arm_bc_s = 2'd1;
    end else begin
      arm_bc_s = 2'd0;
    end
  end

  // Sample storage (no reset needed; validity tracked by pointers/count)
  always_ff @(posedge slave_clk) begin
    if (push_s) mem_q[wr_ptr_q] <= snk_data;
  end

  // FIFO pointers, occupancy and receive budget
  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_remain_q <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_nxt_s;
      count_q     <= count_d;
      rx_remain_q <= rx_remain_d;
    end
  end

  // Control FSM with registered Avalon outputs
  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      wr_remain_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      av_write_q      <= 1'b0;
      av_address_q    <= '0;
      av_burstcount_q <= 2'd0;
      av_byteenable_q <= 4'h0;
      av_writedata_q  <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            addr_q      <= base_addr;
            wr_remain_q <= length;
            if (length == {LEN_W{1'b0}}) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ARM;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (arm_bc_s != 2'd0) begin
            state_q         <= S_BEAT1;
            av_write_q      <= 1'b1;
            av_byteenable_q <= 4'hF;
            av_burstcount_q <= arm_bc_s;
            av_address_q    <= addr_q;
            av_writedata_q  <= mem_q[rd_ptr_q];
          end
        end
        S_BEAT1: begin
          if (!av_waitrequest) begin
            wr_remain_q <= wr_remain_q - LEN_W'(1);
            if (av_burstcount_q == 2'd2) begin
              state_q        <= S_BEAT2;
              av_writedata_q <= mem_q[rd_ptr_nxt_s];
            end else begin
              addr_q          <= addr_q + ADDR_W'(1);
              av_write_q      <= 1'b0;
              av_byteenable_q <= 4'h0;
              if (wr_remain_q == LEN_W'(1)) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_ARM;
              end
            end
          end
        end
        S_BEAT2: begin
          if (!av_waitrequest) begin
            wr_remain_q     <= wr_remain_q - LEN_W'(1);
            addr_q          <= addr_q + ADDR_W'(2);
            av_write_q      <= 1'b0;
            av_byteenable_q <= 4'h0;
            if (wr_remain_q == LEN_W'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ARM;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q         <= S_IDLE;
          busy_q          <= 1'b0;
          done_q          <= 1'b0;
          av_write_q      <= 1'b0;
          av_byteenable_q <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_stream_write_master.sv
// Self-checking bench for ddr2_stream_write_master: directed scenarios plus randomized
// transfers, compared against a burst-list reference model built from the base/length rules.
module tb_ddr2_stream_write_master;
  logic        slave_clk = 1'b0;
  logic        slave_reset_n;
  logic        start;
  logic [27:0] base_addr;
  logic [19:0] length;
  logic        busy, done;
  logic [31:0] snk_data;
  logic        snk_valid, snk_ready;
  logic [27:0] av_address;
  logic [1:0]  av_burstcount;
  logic [3:0]  av_byteenable;
  logic        av_write, av_read;
  logic [31:0] av_writedata;
  logic        av_waitrequest;

  always #5 slave_clk = ~slave_clk;

  ddr2_stream_write_master #(.FIFO_DEPTH(16), .ADDR_W(28), .LEN_W(20)) dut (
    .slave_clk(slave_clk), .slave_reset_n(slave_reset_n), .start(start),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .av_address(av_address), .av_burstcount(av_burstcount), .av_byteenable(av_byteenable),
    .av_write(av_write), .av_read(av_read), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest)
  );

  typedef struct {
    logic [27:0] addr;
    logic [1:0]  bc;
    logic [31:0] data;
  } beat_t;

  beat_t       obs_q[$];
  beat_t       exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] sent_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0, wr_beats = 0, stall_cnt = 0, d0 = 0;
  int wr_mode = 0, hold_left = 0, last_acc_cyc = 0, first_wr_cyc = -1, beat_idx = 0;
  bit gap_en = 1'b0, prev_stall = 1'b0, prev_wr = 1'b0, expect_gap = 1'b0;
  logic [27:0] prev_addr;
  logic [1:0]  prev_bc;
  logic [31:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Environment: drive waitrequest/stream on negedge, observe just before the posedge
  always @(negedge slave_clk) begin : env
    logic wr;
    cyc++;
    case (wr_mode)
      0:       wr = 1'b0;
      1:       wr = 1'b1;
      2:       wr = ($urandom_range(0, 3) == 0);
      default: begin
        wr = (av_write === 1'b1) && (beat_idx == 1) && (hold_left > 0);
        if (wr) hold_left--;
      end
    endcase
    av_waitrequest = wr;
    if (src_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      snk_valid = 1'b1;
      snk_data  = src_q[0];
    end else begin
      snk_valid = 1'b0;
      snk_data  = $urandom;
    end
    #4;
    if (!slave_reset_n) begin
      beat_idx = 0; prev_stall = 1'b0; expect_gap = 1'b0; prev_wr = 1'b0;
    end else begin
      if (snk_valid && snk_ready && src_q.size() > 0) begin
        void'(src_q.pop_front());
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (expect_gap) begin
        chk("gap_between_bursts", 64'(av_write), 64'(1'b0));
        expect_gap = 1'b0;
      end
      if (av_write) begin
        if (!prev_wr && first_wr_cyc < 0) first_wr_cyc = cyc;
        chk("byteenable", 64'(av_byteenable), 64'(4'hF));
        chk("av_read_low", 64'(av_read), 64'(1'b0));
        if (prev_stall) begin
          chk("hold_addr", 64'(av_address), 64'(prev_addr));
          chk("hold_bc", 64'(av_burstcount), 64'(prev_bc));
          chk("hold_data", 64'(av_writedata), 64'(prev_data));
          stall_cnt++;
        end
        if (!av_waitrequest) begin
          beat_t b;
          b.addr = av_address; b.bc = av_burstcount; b.data = av_writedata;
          obs_q.push_back(b);
          wr_beats++;
          if (beat_idx == 0 && av_burstcount == 2'd2) beat_idx = 1;
          else begin beat_idx = 0; expect_gap = 1'b1; end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_addr = av_address; prev_bc = av_burstcount; prev_data = av_writedata;
        end
      end else begin
        if (prev_stall) chk("write_dropped_while_waiting", 64'(av_write), 64'(1'b1));
        prev_stall = 1'b0;
      end
      prev_wr = av_write;
      if (done) begin
        done_cnt++;
        chk("busy_low_with_done", 64'(busy), 64'(1'b0));
      end
    end
  end

  task automatic pulse_start(input logic [27:0] b, input logic [19:0] l);
    @(negedge slave_clk);
    base_addr = b; length = l; start = 1'b1;
    @(negedge slave_clk);
    start = 1'b0;
  endtask

  task automatic add_words(input int n, input bit seq, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = seq ? first + 32'(i) : $urandom;
      src_q.push_back(w);
      sent_q.push_back(w);
    end
  endtask

  task automatic begin_xfer(input logic [27:0] b, input int len, input int nwords,
                            input bit seq, input logic [31:0] first);
    obs_q.delete(); sent_q.delete(); src_q.delete();
    acc_cnt = 0; first_wr_cyc = -1; d0 = done_cnt;
    add_words(nwords, seq, first);
    pulse_start(b, 20'(len));
  endtask

  // Reference: consecutive words, bursts of 2 from the base, a single beat for an odd tail
  task automatic build_exp(input logic [27:0] b, input int len);
    int k, n;
    exp_q.delete();
    k = 0;
    while (k < len) begin
      n = (len - k >= 2) ? 2 : 1;
      for (int j = 0; j < n; j++) begin
        beat_t e;
        e.addr = b + 28'(k);
        e.bc   = 2'(n);
        e.data = (k + j < sent_q.size()) ? sent_q[k + j] : 32'hDEAD_BEEF;
        exp_q.push_back(e);
      end
      k += n;
    end
  endtask

  task automatic finish_xfer(input logic [27:0] b, input int len, input int nleft);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin @(negedge slave_clk); n++; end
    chk("done_timeout", 64'(done_cnt != d0), 64'(1'b1));
    build_exp(b, len);
    chk("beat_count", 64'(obs_q.size()), 64'(len));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk("beat_addr", 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      chk("beat_bc", 64'(obs_q[i].bc), 64'(exp_q[i].bc));
      chk("beat_data", 64'(obs_q[i].data), 64'(exp_q[i].data));
    end
    chk("words_accepted", 64'(acc_cnt), 64'(len));
    chk("words_left", 64'(src_q.size()), 64'(nleft));
    repeat (3) @(negedge slave_clk);
    chk("single_done", 64'(done_cnt), 64'(d0 + 1));
    chk("busy_after_done", 64'(busy), 64'(1'b0));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
    chk({tag, "_done"}, 64'(done), 64'(1'b0));
    chk({tag, "_ready"}, 64'(snk_ready), 64'(1'b0));
    chk({tag, "_write"}, 64'(av_write), 64'(1'b0));
    chk({tag, "_read"}, 64'(av_read), 64'(1'b0));
    chk({tag, "_addr"}, 64'(av_address), 64'(0));
    chk({tag, "_bc"}, 64'(av_burstcount), 64'(0));
    chk({tag, "_be"}, 64'(av_byteenable), 64'(0));
    chk({tag, "_wdata"}, 64'(av_writedata), 64'(0));
  endtask

  initial begin : stim
    int n, wb0;
    logic [27:0] rb;
    int rl, rx;
    slave_reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    snk_valid = 1'b0; snk_data = '0; av_waitrequest = 1'b0;
    repeat (3) @(negedge slave_clk);
    #1 check_outputs_zero("reset");
    @(negedge slave_clk);
    slave_reset_n = 1'b1;

    // Two full bursts from 0x100
    wr_mode = 0; gap_en = 1'b0;
    begin_xfer(28'h0000100, 4, 4, 1'b1, 32'hA0);
    finish_xfer(28'h0000100, 4, 0);
    if (obs_q.size() == 4) chk("t1_second_burst_addr", 64'(obs_q[2].addr), 64'(28'h102));

    // Burst of 2 then tail of 1 across the address wrap
    begin_xfer(28'h0FFFFFFF, 3, 3, 1'b0, 32'h0);
    finish_xfer(28'h0FFFFFFF, 3, 0);
    if (obs_q.size() == 3) chk("wrap_tail_addr", 64'(obs_q[2].addr), 64'(28'h0000001));

    // Five waitrequest cycles during the second beat
    wr_mode = 3; hold_left = 5; stall_cnt = 0;
    begin_xfer(28'h0000700, 4, 4, 1'b1, 32'hC0);
    finish_xfer(28'h0000700, 4, 0);
    chk("stall_cycles", 64'(stall_cnt), 64'(5));

    // FIFO fills while the bridge stalls; nothing lost when it drains
    wr_mode = 1;
    begin_xfer(28'h0000600, 20, 20, 1'b0, 32'h0);
    repeat (40) @(negedge slave_clk);
    chk("fifo_fill_count", 64'(acc_cnt), 64'(16));
    #1 chk("ready_low_when_full", 64'(snk_ready), 64'(1'b0));
    chk("words_waiting", 64'(src_q.size()), 64'(4));
    wr_mode = 2;
    finish_xfer(28'h0000600, 20, 0);

    // First-write latency after the enabling word
    wr_mode = 0;
    begin_xfer(28'h0000800, 1, 0, 1'b0, 32'h0);
    repeat (3) @(negedge slave_clk);
    add_words(1, 1'b0, 32'h0);
    finish_xfer(28'h0000800, 1, 0);
    chk("first_write_latency", 64'(first_wr_cyc - last_acc_cyc), 64'(2));

    // Zero-length transfer
    d0 = done_cnt; wb0 = wr_beats;
    pulse_start(28'h0000400, 20'd0);
    #1;
    chk("len0_done_next_cycle", 64'(done), 64'(1'b1));
    chk("len0_busy_low", 64'(busy), 64'(1'b0));
    repeat (4) @(negedge slave_clk);
    chk("len0_single_done", 64'(done_cnt), 64'(d0 + 1));
    chk("len0_no_writes", 64'(wr_beats), 64'(wb0));

    // Start while busy is ignored
    begin_xfer(28'h0000200, 4, 0, 1'b0, 32'h0);
    repeat (4) @(negedge slave_clk);
    pulse_start(28'h0000300, 20'd2);
    add_words(4, 1'b1, 32'hB0);
    finish_xfer(28'h0000200, 4, 0);
    repeat (5) @(negedge slave_clk);
    chk("ignored_start_no_beats", 64'(obs_q.size()), 64'(4));
    chk("ignored_start_idle", 64'(busy), 64'(1'b0));

    // Reset during BEAT1
    wr_mode = 1;
    begin_xfer(28'h0000500, 4, 4, 1'b0, 32'h0);
    n = 0;
    while (av_write !== 1'b1 && n < 100) begin @(negedge slave_clk); n++; end
    chk("reached_beat1", 64'(av_write), 64'(1'b1));
    #2 slave_reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    src_q.delete();
    repeat (2) @(negedge slave_clk);
    slave_reset_n = 1'b1; wr_mode = 0;
    @(negedge slave_clk);
    #1;
    chk("post_reset_busy", 64'(busy), 64'(1'b0));
    chk("reset_no_done", 64'(done_cnt), 64'(d0));
    begin_xfer(28'h0000900, 5, 5, 1'b0, 32'h0);
    finish_xfer(28'h0000900, 5, 0);

    // Randomized transfers with stream gaps, random waitrequest and surplus samples
    wr_mode = 2; gap_en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      rb = 28'($urandom);
      rl = $urandom_range(1, 40);
      rx = $urandom_range(0, 3);
      begin_xfer(rb, rl, rl + rx, 1'b0, 32'h0);
      finish_xfer(rb, rl, rx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
